// File: rtl/const_drive_checker.sv
// Self-checking constant driver: loads per-channel constants, waits a settle
// window, scans every channel against its constant and reports pass/fail.
module const_drive_checker #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2,
  parameter int SETTLE   = 2,
  parameter logic [WIDTH*CHANNELS-1:0] CONST_VEC = {CHANNELS{4'h5}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CHANNELS-1:0]       force_en,
  input  logic [WIDTH*CHANNELS-1:0] force_val,
  output logic [WIDTH*CHANNELS-1:0] value,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [IDX_W-1:0]          fail_idx,
  output logic [IDX_W:0]            fail_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for start; results of the last run held
  // S_LOAD   | channel registers take their constants
  // S_SETTLE | settle window, cnt_q counts down to 0
  // S_CHECK  | compare one channel per cycle, idx_q selects it
  // S_DONE   | done pulse; pass/fail results already final

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [IDX_W-1:0]          idx_q;
  logic [WIDTH*CHANNELS-1:0] value_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      pass_q;
  logic [IDX_W-1:0]          fail_idx_q;
  logic [IDX_W:0]            fail_cnt_q;

  logic                      mismatch;
  logic [IDX_W:0]            fail_cnt_d;

  always_comb begin
    mismatch   = value_q[int'(idx_q)*WIDTH +: WIDTH] != CONST_VEC[int'(idx_q)*WIDTH +: WIDTH];
    fail_cnt_d = fail_cnt_q + {{IDX_W{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      value_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_cnt_q <= '0;
          end
        end
        S_LOAD: begin
          value_q <= CONST_VEC;
          idx_q   <= '0;
          if (SETTLE == 0) begin
            state_q <= S_CHECK;
          end else begin
            state_q <= S_SETTLE;
            cnt_q   <= CNT_W'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHECK: begin
          fail_cnt_q <= fail_cnt_d;
          if (mismatch && (fail_cnt_q == '0)) fail_idx_q <= idx_q;
          // pass is resolved here so it is already valid while done is high
          if (idx_q == IDX_W'(CHANNELS - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // corruption hook overrides the LOAD write on the same channel
      for (int k = 0; k < CHANNELS; k++) begin
        if (force_en[k]) value_q[k*WIDTH +: WIDTH] <= force_val[k*WIDTH +: WIDTH];
      end
    end
  end

  assign value    = value_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_const_drive_checker.sv
// Scoreboard bench for const_drive_checker: default instance plus a
// single-channel, zero-settle instance.
module tb_const_drive_checker;

  typedef struct {
    int          cyc;
    logic        pass;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, start0, start1;
  logic [3:0]  force_en0;
  logic [15:0] force_val0;
  logic [15:0] value0;
  logic        busy0, done0, pass0;
  logic [1:0]  fail_idx0;
  logic [2:0]  fail_cnt0;
  logic [0:0]  force_en1;
  logic [3:0]  force_val1;
  logic [3:0]  value1;
  logic        busy1, done1, pass1;
  logic [0:0]  fail_idx1;
  logic [1:0]  fail_cnt1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   dcnt0 = 0;
  int   dcnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  const_drive_checker u0 (
    .clk(clk), .rst(rst0), .start(start0), .force_en(force_en0), .force_val(force_val0),
    .value(value0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_idx(fail_idx0), .fail_cnt(fail_cnt0)
  );

  const_drive_checker #(
    .WIDTH(4), .CHANNELS(1), .IDX_W(1), .SETTLE(0), .CONST_VEC(4'h5)
  ) u1 (
    .clk(clk), .rst(rst1), .start(start1), .force_en(force_en1), .force_val(force_val1),
    .value(value1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_idx(fail_idx1), .fail_cnt(fail_cnt1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard side: every done must match the oldest expected run
  always @(negedge clk) begin
    exp_t e;
    if (done0 === 1'b1) begin
      dcnt0++;
      if (q0.size() == 0) check_val("u0_unexpected_done", done0, 1'b0);
      else begin
        e = q0.pop_front();
        check_val("u0_latency", cyc, e.cyc);
        check_val("u0_pass", pass0, e.pass);
        check_val("u0_fail_idx", fail_idx0, e.idx);
        check_val("u0_fail_cnt", fail_cnt0, e.cnt);
        check_val("u0_value", value0, e.val);
      end
    end
    if (done1 === 1'b1) begin
      dcnt1++;
      if (q1.size() == 0) check_val("u1_unexpected_done", done1, 1'b0);
      else begin
        e = q1.pop_front();
        check_val("u1_latency", cyc, e.cyc);
        check_val("u1_pass", pass1, e.pass);
        check_val("u1_fail_idx", fail_idx1, e.idx[0:0]);
        check_val("u1_fail_cnt", fail_cnt1, e.cnt[1:0]);
        check_val("u1_value", value1, e.val[3:0]);
      end
    end
  end

  task automatic pulse_start(input bit which, output int edge_cyc);
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run0(input logic p, input logic [1:0] idx, input logic [2:0] cnt,
                      input logic [15:0] val);
    int   n;
    exp_t e;
    pulse_start(1'b0, n);
    e.cyc = n + 7; e.pass = p; e.idx = idx; e.cnt = cnt; e.val = val;
    q0.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check_val("drain_timeout", q0.size() + q1.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int   n, d;
    exp_t e;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    force_en0 = '0; force_val0 = '0; force_en1 = '0; force_val1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    check_val("rst_value", value0, 16'h0);
    check_val("rst_busy", busy0, 1'b0);
    check_val("rst_done", done0, 1'b0);
    check_val("rst_pass", pass0, 1'b0);
    check_val("rst_fail_idx", fail_idx0, 2'd0);
    check_val("rst_fail_cnt", fail_cnt0, 3'd0);
    check_val("rst_u1_value", value1, 4'h0);
    check_val("rst_u1_busy", busy1, 1'b0);

    // T1 clean run
    run0(1'b1, 2'd0, 3'd0, 16'h5555);
    check_val("t1_busy", busy0, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    check_val("t1_pass_held", pass0, 1'b1);
    check_val("t1_idle", busy0, 1'b0);

    // T2 one corrupted channel
    force_en0 = 4'b0100; force_val0 = 16'h0A00;
    run0(1'b0, 2'd2, 3'd1, 16'h5A55);
    wait_drain();
    force_en0 = '0;
    repeat (3) @(negedge clk);
    check_val("t2_pass_held", pass0, 1'b0);
    check_val("t2_cnt_held", fail_cnt0, 3'd1);

    // T3 two corrupted channels, first failure reported
    force_en0 = 4'b1010; force_val0 = 16'h0000;
    run0(1'b0, 2'd1, 3'd2, 16'h0505);
    wait_drain();
    force_en0 = '0;

    // T4 start while busy is ignored
    d = dcnt0;
    run0(1'b1, 2'd0, 3'd0, 16'h5555);
    repeat (2) @(posedge clk);
    #1;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_drain();
    repeat (10) @(negedge clk);
    check_val("t4_done_count", dcnt0 - d, 1);
    check_val("t4_idle", busy0, 1'b0);

    // T5 reset in the second settle cycle aborts the run
    d = dcnt0;
    pulse_start(1'b0, n);
    repeat (2) @(posedge clk);
    #1;
    check_val("t5_busy_before", busy0, 1'b1);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    check_val("t5_busy", busy0, 1'b0);
    check_val("t5_value", value0, 16'h0);
    repeat (12) @(negedge clk);
    check_val("t5_no_done", dcnt0 - d, 0);
    run0(1'b1, 2'd0, 3'd0, 16'h5555);
    wait_drain();

    // T6 single channel, no settle window
    pulse_start(1'b1, n);
    e.cyc = n + 2; e.pass = 1'b1; e.idx = 2'd0; e.cnt = 3'd0; e.val = 16'h0005;
    q1.push_back(e);
    wait_drain();
    check_val("t6_done_count", dcnt1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
